// File: rtl/load_store_unit_pkg.sv
// Shared encodings and request validation for the load/store unit.
// Also holds the unit's state type.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  // A request is rejected for a reserved size, misalignment, or an address past the memory.
  function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr,
                                     input int unsigned mem_bytes);
    logic bad;
    bad = 1'b0;
    if (size == 2'b11) bad = 1'b1;
    if (size == SZ_HALF && addr[0]) bad = 1'b1;
    if (size == SZ_WORD && addr[1:0] != 2'b00) bad = 1'b1;
    if (addr >= 32'(mem_bytes)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_byte_lane_unit.sv
// Little-endian lane handling: extracts sub-word load values and merges
// sub-word store data into a full memory word.
module byte_lane_unit
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val   = word[{lane, 3'b000} +: 8];
    half_val   = word[{lane[1], 4'b0000} +: 16];
    load_data  = word;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{sign_ext & byte_val[7]}}, byte_val};
        store_word = word;
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{sign_ext & half_val[15]}}, half_val};
        store_word = word;
        store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-only data memory; sub-word stores are
// performed as read-modify-write. All outputs except req_ready are registered.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  output logic        mem_write
);

  lsu_state_e  state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] lane_load;
  logic [31:0] lane_store;

  assign req_ready = (state == IDLE) && !reset;

  // The read word is consumed straight off mem_rdata at the end of RD, so the
  // merged store word and the extracted load value are registered directly.
  byte_lane_unit u_lanes (
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .lane       (lane_q),
    .size       (size_q),
    .sign_ext   (signed_q),
    .load_data  (lane_load),
    .store_word (lane_store)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lane_q     <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lane_q   <= req_addr[1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            write_q  <= req_write;
            wdata_q  <= req_wdata;
            if (req_error(req_size, req_addr, MEM_BYTES)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_write && req_size == SZ_WORD) begin
              state     <= WR;
              mem_write <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_wdata;
            end else begin
              state    <= RD;
              mem_read <= 1'b1;
              mem_addr <= {req_addr[31:2], 2'b00};
            end
          end
        end
        RD: begin
          if (write_q) begin
            state     <= WR;
            mem_write <= 1'b1;
            mem_wdata <= lane_store;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= lane_load;
          end
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, randomized traffic
// against a byte-array memory model, handshake and mid-operation reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        mem_write;

  int tests = 0;
  int fails = 0;

  logic [31:0] tb_mem [0:63];
  logic [7:0]  ref_b  [0:255];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_write(mem_write)
  );

  assign mem_rdata = tb_mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) tb_mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    int unsigned nb;
    if (sz == 2'b11) return 1'b1;
    nb = 1 << sz;
    if (a % nb != 0) return 1'b1;
    return (a > 255);
  endfunction

  function automatic logic [31:0] model_word(input int unsigned a);
    int unsigned b;
    b = a & 32'hFC;
    return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                             input int unsigned a);
    int unsigned nb;
    logic [63:0] v;
    nb = 1 << sz;
    v = '0;
    for (int unsigned i = 0; i < nb; i++) v = v | (64'(ref_b[a+i]) << (8*i));
    if (sg && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] sz, input int unsigned a, input logic [31:0] wd);
    int unsigned nb;
    nb = 1 << sz;
    for (int unsigned i = 0; i < nb; i++) ref_b[a+i] = wd[8*i +: 8];
  endtask

  // Issues one request from a negedge, observes it to completion, checks it.
  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
    int lat, rd_cyc, wr_cyc, exp_rd_cyc, exp_wr_cyc, waited;
    logic [31:0] rd, wr_data, acc_addr, exp_wword;
    logic er, overlap, busy_rdy, stray;
    lat = -1; rd_cyc = -1; wr_cyc = -1; rd = '0; er = 1'b0;
    wr_data = '0; acc_addr = '0; overlap = 0; busy_rdy = 0; stray = 0;
    waited = 0;
    while (!req_ready && waited < 10) begin @(negedge clk); waited++; end
    chk({tag, "_ready_wait"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 6 && lat < 0; c++) begin
      if (mem_read) begin rd_cyc = c; acc_addr = mem_addr; end
      if (mem_write) begin wr_cyc = c; wr_data = mem_wdata; acc_addr = mem_addr; end
      if (mem_read && mem_write) overlap = 1'b1;
      if (req_ready) busy_rdy = 1'b1;
      if (resp_valid) begin lat = c; rd = resp_rdata; er = resp_err; end
      else if (resp_rdata != 0 || resp_err) stray = 1'b1;
      @(negedge clk);
    end
    exp_rd_cyc = (!exp_err && (!w || sz != 2'b10)) ? 1 : -1;
    exp_wr_cyc = (!exp_err && w) ? ((sz == 2'b10) ? 1 : 2) : -1;
    exp_wword = '0;
    if (!exp_err && w) begin
      model_store(sz, a, wd);
      exp_wword = model_word(a);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_read_cycle"}, 32'(rd_cyc), 32'(exp_rd_cyc));
    chk({tag, "_write_cycle"}, 32'(wr_cyc), 32'(exp_wr_cyc));
    if (exp_wr_cyc > 0) chk({tag, "_wdata"}, wr_data, exp_wword);
    if (!exp_err) chk({tag, "_mem_addr"}, acc_addr, {a[31:2], 2'b00});
    chk({tag, "_rd_wr_overlap"}, 32'(overlap), 32'd0);
    chk({tag, "_ready_while_busy"}, 32'(busy_rdy), 32'd0);
    chk({tag, "_resp_idle_zero"}, 32'(stray), 32'd0);
    chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [6:0] rdy_pat, rv_pat;
    logic [31:0] hs_rd [2];
    logic [31:0] exp_a, exp_b, pre_word;
    int acc, nresp;
    logic bad;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_mem_ctl", {30'd0, mem_read, mem_write}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_resp", {31'd0, resp_valid} | resp_rdata | {31'd0, resp_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(req_ready), 32'd1);

    // w, size, signed, addr, wdata, err, rdata, latency
    tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h10,  32'h8899AABB, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        1'b0, 32'hFFFFFFAA, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h11,  32'h0,        1'b0, 32'h000000AA, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        1'b0, 32'hFFFF8899, 2});
    tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h13,  32'h00000055, 1'b0, 32'h0,        3});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        1'b0, 32'h5599AABB, 2});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h20,  32'hDEADBEEF, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h22,  32'h00001234, 1'b0, 32'h0,        3});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        1'b0, 32'h1234BEEF, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h10,  32'h0,        1'b0, 32'h0000AABB, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h10,  32'h0,        1'b0, 32'hFFFFAABB, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        1'b0, 32'h00000055, 2});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 32'hFC,  32'hA1B2C3D4, 1'b0, 32'h0,        2});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 32'hFF,  32'h0,        1'b0, 32'hFFFFFFA1, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 32'hFE,  32'h0,        1'b0, 32'h0000A1B2, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 32'h13,  32'h0,        1'b1, 32'h0,        1});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        1'b1, 32'h0,        1});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 1'b1, 32'h0,        1});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        1'b1, 32'h0,        1});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h100, 32'h0,        1'b1, 32'h0,        1});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h1,   1'b1, 32'h0,        1});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        1'b0, 32'h1234BEEF, 2});
    foreach (tbl[i])
      txn($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
          tbl[i].err, tbl[i].rd, tbl[i].lat);

    // Handshake: two back-to-back loads with req_valid held high throughout.
    exp_a = model_word(32'h10);
    exp_b = model_word(32'h20);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = '0;
    acc = 0; nresp = 0; rdy_pat = '0; rv_pat = '0; hs_rd[0] = '0; hs_rd[1] = '0;
    for (int c = 0; c < 7; c++) begin
      rdy_pat[c] = req_ready;
      rv_pat[c]  = resp_valid;
      if (resp_valid && nresp < 2) begin hs_rd[nresp] = resp_rdata; nresp++; end
      if (req_ready && req_valid) begin
        acc++;
        @(posedge clk); #1;
        if (acc == 1) req_addr = 32'h20; else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("hs_ready_pattern", 32'(rdy_pat), 32'b1001001);
    chk("hs_resp_pattern", 32'(rv_pat), 32'b0100100);
    chk("hs_first_rdata", hs_rd[0], exp_a);
    chk("hs_second_rdata", hs_rd[1], exp_b);
    repeat (2) @(negedge clk);

    // Reset during RD of a byte store: the word must be left untouched.
    pre_word = model_word(32'h10);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_in_rd", 32'(mem_read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_write", 32'(mem_write), 32'd0);
    chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
    chk("rst_mid_ready_low", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_after", 32'(req_ready), 32'd1);
    bad = 1'b0;
    repeat (3) begin
      if (mem_write || resp_valid) bad = 1'b1;
      @(negedge clk);
    end
    chk("rst_mid_quiet", 32'(bad), 32'd0);
    chk("rst_mid_mem_word", tb_mem[4], pre_word);
    txn("rst_readback", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, pre_word, 2);

    // Fill every word, then randomized traffic against the byte-level model.
    for (int unsigned i = 0; i < 64; i++)
      txn("fill", 1'b1, 2'b10, 1'b0, 32'(i*4), $urandom, 1'b0, 32'h0, 2);
    for (int n = 0; n < 200; n++) begin
      logic w, sg, e;
      logic [1:0] sz;
      logic [31:0] a, rd;
      int unsigned k, r, lat;
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      k  = $urandom_range(0, 9);
      if (k == 0) a = 32'd256 + $urandom_range(0, 1023);
      else begin
        a = $urandom_range(0, 255);
        if (k > 2 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      end
      e   = model_err(sz, a);
      rd  = (!e && !w) ? model_load(sz, sg, a) : 32'h0;
      lat = e ? 1 : (w && sz != 2'b10) ? 3 : 2;
      txn($sformatf("rand%0d", n), w, sz, sg, a, $urandom, e, rd, lat);
    end
    for (int unsigned i = 0; i < 64; i++)
      chk($sformatf("final_word%0d", i), tb_mem[i], model_word(i*4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
